// File: rtl/vga_timing_engine_pkg.sv
// Shared types and default 640x480@60 timing for the VGA timing engine.
package vga_timing_engine_pkg;

    localparam int VGA_H_BP   = 48;
    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;

    localparam int VGA_V_BP   = 33;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;

    localparam logic VGA_H_ACTIVE_POL = 1'b0;
    localparam logic VGA_V_ACTIVE_POL = 1'b0;

    // Timing-update state: either idle (ready) or holding a pending timing set
    typedef enum logic {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_t;

    // Per-pixel control bits carried down the latency-matching delay line
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic line_start;
        logic frame_start;
    } ctrl_bits_t;

    localparam ctrl_bits_t CTRL_IDLE = '0;

endpackage

// File: rtl/vga_timing_engine_if.sv
// Bus bundle between the timing engine, its pixel source, config master and DAC pins.
interface vga_timing_engine_if #(
    parameter int COLOR_BITS = 4,
    parameter int CNT_W      = 11
);
    logic [CNT_W-1:0]      cfg_h_bp;
    logic [CNT_W-1:0]      cfg_h_vis;
    logic [CNT_W-1:0]      cfg_h_fp;
    logic [CNT_W-1:0]      cfg_h_sync;
    logic [CNT_W-1:0]      cfg_v_bp;
    logic [CNT_W-1:0]      cfg_v_vis;
    logic [CNT_W-1:0]      cfg_v_fp;
    logic [CNT_W-1:0]      cfg_v_sync;
    logic                  cfg_valid;
    logic                  cfg_ready;

    logic                  req;
    logic [CNT_W-1:0]      req_x;
    logic [CNT_W-1:0]      req_y;
    logic [COLOR_BITS-1:0] in_r;
    logic [COLOR_BITS-1:0] in_g;
    logic [COLOR_BITS-1:0] in_b;

    logic [COLOR_BITS-1:0] out_vga_r;
    logic [COLOR_BITS-1:0] out_vga_g;
    logic [COLOR_BITS-1:0] out_vga_b;
    logic                  out_hsync;
    logic                  out_vsync;
    logic                  out_de;
    logic                  out_line_start;
    logic                  out_frame_start;
    logic [15:0]           out_frame_count;

    // Engine side
    modport slave (
        input  cfg_h_bp, cfg_h_vis, cfg_h_fp, cfg_h_sync,
        input  cfg_v_bp, cfg_v_vis, cfg_v_fp, cfg_v_sync,
        input  cfg_valid,
        output cfg_ready,
        output req, req_x, req_y,
        input  in_r, in_g, in_b,
        output out_vga_r, out_vga_g, out_vga_b,
        output out_hsync, out_vsync, out_de,
        output out_line_start, out_frame_start, out_frame_count
    );

    // Environment side: config master, pixel source and display sink
    modport master (
        output cfg_h_bp, cfg_h_vis, cfg_h_fp, cfg_h_sync,
        output cfg_v_bp, cfg_v_vis, cfg_v_fp, cfg_v_sync,
        output cfg_valid,
        input  cfg_ready,
        input  req, req_x, req_y,
        output in_r, in_g, in_b,
        input  out_vga_r, out_vga_g, out_vga_b,
        input  out_hsync, out_vsync, out_de,
        input  out_line_start, out_frame_start, out_frame_count
    );

endinterface

// File: rtl/vga_timing_engine_axis_counter.sv
// One raster axis: position counter with wrap, plus visible/sync decode and active coordinate.
module vga_timing_engine_axis_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] bp,
    input  logic [CNT_W-1:0] vis,
    input  logic [CNT_W-1:0] fp,
    input  logic [CNT_W-1:0] sync,
    output logic [CNT_W-1:0] pos,
    output logic [CNT_W-1:0] coord,
    output logic             at_end,
    output logic             visible,
    output logic             sync_act
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] fp_start;
    logic [CNT_W-1:0] sync_start;
    logic [CNT_W-1:0] last_pos;

    // Segment order is back porch, visible, front porch, sync
    assign fp_start   = bp + vis;
    assign sync_start = fp_start + fp;
    assign last_pos   = sync_start + sync - ONE;

    assign at_end   = (pos >= last_pos);
    assign visible  = (pos >= bp) && (pos < fp_start);
    assign sync_act = (pos >= sync_start);
    assign coord    = visible ? (pos - bp) : '0;

    // Position advances when told to and wraps after the last sync position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (clear) begin
            pos <= '0;
        end else if (advance) begin
            pos <= at_end ? '0 : (pos + ONE);
        end
    end

endmodule

// File: rtl/vga_timing_engine.sv
// VGA raster generator with frame-boundary timing updates and pixel-source latency matching.
module vga_timing_engine
    import vga_timing_engine_pkg::*;
#(
    parameter int   COLOR_BITS    = 4,
    parameter int   CNT_W         = 11,
    parameter int   PIXEL_LATENCY = 2,
    parameter logic H_ACTIVE_POL  = VGA_H_ACTIVE_POL,
    parameter logic V_ACTIVE_POL  = VGA_V_ACTIVE_POL,
    parameter int   DEF_H_BP      = VGA_H_BP,
    parameter int   DEF_H_VIS     = VGA_H_VIS,
    parameter int   DEF_H_FP      = VGA_H_FP,
    parameter int   DEF_H_SYNC    = VGA_H_SYNC,
    parameter int   DEF_V_BP      = VGA_V_BP,
    parameter int   DEF_V_VIS     = VGA_V_VIS,
    parameter int   DEF_V_FP      = VGA_V_FP,
    parameter int   DEF_V_SYNC    = VGA_V_SYNC
) (
    input  logic                clk_pixel,
    input  logic                rst_n,
    input  logic                en,
    vga_timing_engine_if.slave  bus
);

    // Packed timing set, index 7..4 horizontal bp/vis/fp/sync, 3..0 vertical
    localparam logic [7:0][CNT_W-1:0] DEF_CFG = {
        CNT_W'(DEF_H_BP), CNT_W'(DEF_H_VIS), CNT_W'(DEF_H_FP), CNT_W'(DEF_H_SYNC),
        CNT_W'(DEF_V_BP), CNT_W'(DEF_V_VIS), CNT_W'(DEF_V_FP), CNT_W'(DEF_V_SYNC)
    };

    cfg_state_t               cfg_state;
    logic [7:0][CNT_W-1:0]    shadow_cfg;
    logic [7:0][CNT_W-1:0]    pend_cfg;
    logic [7:0][CNT_W-1:0]    cfg_in;

    logic [CNT_W-1:0] h_pos, h_coord, v_pos, v_coord;
    logic             h_end, h_vis, h_sync_act;
    logic             v_end, v_vis, v_sync_act;
    logic             frame_end_pos;
    logic             pix_visible;
    logic [15:0]      frame_count;

    ctrl_bits_t       raw_ctrl;
    ctrl_bits_t       dline [PIXEL_LATENCY];
    ctrl_bits_t       tail;

    assign cfg_in = {bus.cfg_h_bp, bus.cfg_h_vis, bus.cfg_h_fp, bus.cfg_h_sync,
                     bus.cfg_v_bp, bus.cfg_v_vis, bus.cfg_v_fp, bus.cfg_v_sync};

    vga_timing_engine_axis_counter #(.CNT_W(CNT_W)) u_h_axis (
        .clk      (clk_pixel),
        .rst_n    (rst_n),
        .clear    (!en),
        .advance  (en),
        .bp       (shadow_cfg[7]),
        .vis      (shadow_cfg[6]),
        .fp       (shadow_cfg[5]),
        .sync     (shadow_cfg[4]),
        .pos      (h_pos),
        .coord    (h_coord),
        .at_end   (h_end),
        .visible  (h_vis),
        .sync_act (h_sync_act)
    );

    vga_timing_engine_axis_counter #(.CNT_W(CNT_W)) u_v_axis (
        .clk      (clk_pixel),
        .rst_n    (rst_n),
        .clear    (!en),
        .advance  (en && h_end),
        .bp       (shadow_cfg[3]),
        .vis      (shadow_cfg[2]),
        .fp       (shadow_cfg[1]),
        .sync     (shadow_cfg[0]),
        .pos      (v_pos),
        .coord    (v_coord),
        .at_end   (v_end),
        .visible  (v_vis),
        .sync_act (v_sync_act)
    );

    assign frame_end_pos   = h_end && v_end;
    assign pix_visible     = h_vis && v_vis;
    assign bus.req         = pix_visible;
    assign bus.req_x       = pix_visible ? h_coord : '0;
    assign bus.req_y       = pix_visible ? v_coord : '0;
    assign bus.cfg_ready   = (cfg_state == CFG_IDLE);
    assign bus.out_frame_count = frame_count;
    assign tail            = dline[PIXEL_LATENCY-1];

    // Control bits for the current raster position; all inactive while stopped
    always_comb begin
        raw_ctrl             = CTRL_IDLE;
        raw_ctrl.hsync       = en && h_sync_act;
        raw_ctrl.vsync       = en && v_sync_act;
        raw_ctrl.de          = en && pix_visible;
        raw_ctrl.line_start  = en && (h_pos == '0);
        raw_ctrl.frame_start = en && (h_pos == '0) && (v_pos == '0);
    end

    // Timing update: capture into pending, promote to shadow only on the frame-end cycle
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            cfg_state  <= CFG_IDLE;
            shadow_cfg <= DEF_CFG;
            pend_cfg   <= '0;
        end else begin
            case (cfg_state)
                CFG_IDLE: begin
                    if (bus.cfg_valid) begin
                        pend_cfg  <= cfg_in;
                        cfg_state <= CFG_PENDING;
                    end
                end
                CFG_PENDING: begin
                    if (frame_end_pos) begin
                        shadow_cfg <= pend_cfg;
                        cfg_state  <= CFG_IDLE;
                    end
                end
                default: cfg_state <= CFG_IDLE;
            endcase
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (en && frame_end_pos) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    // Delay line matching control bits to the pixel source latency; flushed while stopped
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIXEL_LATENCY; i++) dline[i] <= CTRL_IDLE;
        end else if (!en) begin
            for (int i = 0; i < PIXEL_LATENCY; i++) dline[i] <= CTRL_IDLE;
        end else begin
            dline[0] <= raw_ctrl;
            for (int i = 1; i < PIXEL_LATENCY; i++) dline[i] <= dline[i-1];
        end
    end

    // Output register: colour sampled alongside its delayed control bits, polarity applied here
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_vga_r       <= '0;
            bus.out_vga_g       <= '0;
            bus.out_vga_b       <= '0;
            bus.out_de          <= 1'b0;
            bus.out_hsync       <= ~H_ACTIVE_POL;
            bus.out_vsync       <= ~V_ACTIVE_POL;
            bus.out_line_start  <= 1'b0;
            bus.out_frame_start <= 1'b0;
        end else begin
            bus.out_vga_r       <= tail.de ? bus.in_r : '0;
            bus.out_vga_g       <= tail.de ? bus.in_g : '0;
            bus.out_vga_b       <= tail.de ? bus.in_b : '0;
            bus.out_de          <= tail.de;
            bus.out_hsync       <= tail.hsync ? H_ACTIVE_POL : ~H_ACTIVE_POL;
            bus.out_vsync       <= tail.vsync ? V_ACTIVE_POL : ~V_ACTIVE_POL;
            bus.out_line_start  <= tail.line_start;
            bus.out_frame_start <= tail.frame_start;
        end
    end

endmodule

// File: tb/tb_vga_timing_engine.sv
// Directed bench for vga_timing_engine using a 15x8 raster (H 2/8/2/3, V 1/4/1/2).
module tb_vga_timing_engine;

    logic clk_pixel = 1'b0;
    logic rst_n;
    logic en;

    int c;
    int assert_count;
    int fail_count;

    logic [3:0] pipe_x1, pipe_x2, pipe_y1, pipe_y2;

    vga_timing_engine_if #(.COLOR_BITS(4), .CNT_W(11)) bus ();

    vga_timing_engine #(
        .COLOR_BITS    (4),
        .CNT_W         (11),
        .PIXEL_LATENCY (2),
        .H_ACTIVE_POL  (1'b0),
        .V_ACTIVE_POL  (1'b0),
        .DEF_H_BP      (2),
        .DEF_H_VIS     (8),
        .DEF_H_FP      (2),
        .DEF_H_SYNC    (3),
        .DEF_V_BP      (1),
        .DEF_V_VIS     (4),
        .DEF_V_FP      (1),
        .DEF_V_SYNC    (2)
    ) dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .en        (en),
        .bus       (bus)
    );

    // Pixel clock
    always #5 clk_pixel = ~clk_pixel;

    // Pixel source with two cycles of latency: returns req_x on red, req_y on green
    always @(posedge clk_pixel) begin
        pipe_x1 <= bus.req_x[3:0];
        pipe_x2 <= pipe_x1;
        pipe_y1 <= bus.req_y[3:0];
        pipe_y2 <= pipe_y1;
    end

    assign bus.in_r = pipe_x2;
    assign bus.in_g = pipe_y2;
    assign bus.in_b = 4'h5;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, c, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
        c++;
    endtask

    task automatic runTo(input int target);
        while (c < target) tick();
    endtask

    task automatic applyStimulus(input int hbp, input int hvis, input int hfp, input int hsync,
                                 input int vbp, input int vvis, input int vfp, input int vsync);
        bus.cfg_h_bp   = 11'(hbp);
        bus.cfg_h_vis  = 11'(hvis);
        bus.cfg_h_fp   = 11'(hfp);
        bus.cfg_h_sync = 11'(hsync);
        bus.cfg_v_bp   = 11'(vbp);
        bus.cfg_v_vis  = 11'(vvis);
        bus.cfg_v_fp   = 11'(vfp);
        bus.cfg_v_sync = 11'(vsync);
        bus.cfg_valid  = 1'b1;
        tick();
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req"},     32'(bus.req), 0);
        checkOutput({tag, "_req_x"},   32'(bus.req_x), 0);
        checkOutput({tag, "_req_y"},   32'(bus.req_y), 0);
        checkOutput({tag, "_de"},      32'(bus.out_de), 0);
        checkOutput({tag, "_r"},       32'(bus.out_vga_r), 0);
        checkOutput({tag, "_g"},       32'(bus.out_vga_g), 0);
        checkOutput({tag, "_b"},       32'(bus.out_vga_b), 0);
        checkOutput({tag, "_hsync"},   32'(bus.out_hsync), 1);
        checkOutput({tag, "_vsync"},   32'(bus.out_vsync), 1);
        checkOutput({tag, "_lstart"},  32'(bus.out_line_start), 0);
        checkOutput({tag, "_fstart"},  32'(bus.out_frame_start), 0);
        checkOutput({tag, "_fcount"},  32'(bus.out_frame_count), 0);
        checkOutput({tag, "_cfg_rdy"}, 32'(bus.cfg_ready), 1);
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int h, v, vis, p, ph, pv, pvis;
        int first_req, hs_low, vs_low, de_cnt, ls_cnt, fs_first, fs_second;

        assert_count = 0;
        fail_count   = 0;
        c            = 0;
        rst_n        = 1'b0;
        en           = 1'b1;
        bus.cfg_valid  = 1'b0;
        bus.cfg_h_bp   = '0;
        bus.cfg_h_vis  = '0;
        bus.cfg_h_fp   = '0;
        bus.cfg_h_sync = '0;
        bus.cfg_v_bp   = '0;
        bus.cfg_v_vis  = '0;
        bus.cfg_v_fp   = '0;
        bus.cfg_v_sync = '0;

        // Reset values and first frame with default timing
        repeat (3) @(posedge clk_pixel);
        #1;
        checkResetOutputs("in_reset");
        @(negedge clk_pixel);
        rst_n = 1'b1;
        c = 0;
        #1;

        first_req = -1; hs_low = 0; vs_low = 0; de_cnt = 0; ls_cnt = 0;
        fs_first = -1; fs_second = -1;
        while (c < 126) begin
            h   = c % 15;
            v   = (c / 15) % 8;
            vis = (h >= 2 && h < 10 && v >= 1 && v < 5) ? 1 : 0;
            checkOutput("req",   32'(bus.req), vis);
            checkOutput("req_x", 32'(bus.req_x), (vis != 0) ? h - 2 : 0);
            checkOutput("req_y", 32'(bus.req_y), (vis != 0) ? v - 1 : 0);
            if (vis != 0 && first_req < 0) first_req = c;
            if (c >= 3) begin
                p    = c - 3;
                ph   = p % 15;
                pv   = (p / 15) % 8;
                pvis = (ph >= 2 && ph < 10 && pv >= 1 && pv < 5) ? 1 : 0;
                checkOutput("out_de",     32'(bus.out_de), pvis);
                checkOutput("out_r",      32'(bus.out_vga_r), (pvis != 0) ? ph - 2 : 0);
                checkOutput("out_g",      32'(bus.out_vga_g), (pvis != 0) ? pv - 1 : 0);
                checkOutput("out_b",      32'(bus.out_vga_b), (pvis != 0) ? 5 : 0);
                checkOutput("out_hsync",  32'(bus.out_hsync), (ph >= 12) ? 0 : 1);
                checkOutput("out_vsync",  32'(bus.out_vsync), (pv >= 6) ? 0 : 1);
                checkOutput("out_lstart", 32'(bus.out_line_start), (ph == 0) ? 1 : 0);
                checkOutput("out_fstart", 32'(bus.out_frame_start), (ph == 0 && pv == 0) ? 1 : 0);
                if (c < 123) begin
                    if (bus.out_hsync == 1'b0) hs_low++;
                    if (bus.out_vsync == 1'b0) vs_low++;
                    if (bus.out_de) de_cnt++;
                    if (bus.out_line_start) ls_cnt++;
                end
                if (bus.out_frame_start) begin
                    if (fs_first < 0) fs_first = c;
                    else if (fs_second < 0) fs_second = c;
                end
            end else begin
                checkOutput("early_de",    32'(bus.out_de), 0);
                checkOutput("early_hsync", 32'(bus.out_hsync), 1);
                checkOutput("early_vsync", 32'(bus.out_vsync), 1);
                checkOutput("early_r",     32'(bus.out_vga_r), 0);
            end
            if (c == 119) checkOutput("fcount_before_end", 32'(bus.out_frame_count), 0);
            if (c == 120) checkOutput("fcount_after_end",  32'(bus.out_frame_count), 1);
            tick();
        end
        checkOutput("first_req_cycle", first_req, 17);
        checkOutput("hsync_low_cycles", hs_low, 24);
        checkOutput("vsync_low_cycles", vs_low, 30);
        checkOutput("de_cycles", de_cnt, 32);
        checkOutput("line_starts", ls_cnt, 8);
        checkOutput("first_fstart", fs_first, 3);
        checkOutput("frame_period", fs_second - fs_first, 120);

        // Mid-frame update to H_VIS=4: current frame unchanged, next frame 11-cycle lines
        checkOutput("t3_ready_before", 32'(bus.cfg_ready), 1);
        applyStimulus(2, 4, 2, 3, 1, 4, 1, 2);
        checkOutput("t3_ready_pending", 32'(bus.cfg_ready), 0);
        runTo(137); checkOutput("t3_old_req_first", 32'(bus.req), 1);
        checkOutput("t3_old_req_x0", 32'(bus.req_x), 0);
        runTo(144); checkOutput("t3_old_req_last", 32'(bus.req), 1);
        checkOutput("t3_old_req_x7", 32'(bus.req_x), 7);
        runTo(145); checkOutput("t3_old_req_end", 32'(bus.req), 0);
        runTo(239); checkOutput("t3_ready_at_end", 32'(bus.cfg_ready), 0);
        runTo(240); checkOutput("t3_ready_after", 32'(bus.cfg_ready), 1);
        checkOutput("t3_fcount", 32'(bus.out_frame_count), 2);
        runTo(243); checkOutput("t3_lstart0", 32'(bus.out_line_start), 1);
        checkOutput("t3_fstart", 32'(bus.out_frame_start), 1);
        runTo(250); checkOutput("t3_hsync_fp", 32'(bus.out_hsync), 1);
        runTo(251); checkOutput("t3_hsync_sync", 32'(bus.out_hsync), 0);
        runTo(253); checkOutput("t3_new_req_first", 32'(bus.req), 1);
        checkOutput("t3_new_req_x0", 32'(bus.req_x), 0);
        checkOutput("t3_no_lstart", 32'(bus.out_line_start), 0);
        runTo(254); checkOutput("t3_lstart1", 32'(bus.out_line_start), 1);
        runTo(256); checkOutput("t3_new_req_x3", 32'(bus.req_x), 3);
        runTo(257); checkOutput("t3_new_req_end", 32'(bus.req), 0);

        // Update captured on the exact frame-end cycle applies one frame later
        runTo(327); checkOutput("t4_ready_at_end", 32'(bus.cfg_ready), 1);
        checkOutput("t4_fcount_before", 32'(bus.out_frame_count), 2);
        applyStimulus(2, 8, 2, 3, 1, 4, 1, 2);
        checkOutput("t4_ready_pending", 32'(bus.cfg_ready), 0);
        checkOutput("t4_fcount_after", 32'(bus.out_frame_count), 3);
        runTo(341); checkOutput("t4_still_short_req", 32'(bus.req), 1);
        runTo(344); checkOutput("t4_still_short_x3", 32'(bus.req_x), 3);
        runTo(345); checkOutput("t4_still_short_end", 32'(bus.req), 0);
        runTo(415); checkOutput("t4_ready_at_end2", 32'(bus.cfg_ready), 0);
        runTo(416); checkOutput("t4_ready_after", 32'(bus.cfg_ready), 1);
        runTo(433); checkOutput("t4_wide_req_x0", 32'(bus.req_x), 0);
        checkOutput("t4_wide_req", 32'(bus.req), 1);
        runTo(440); checkOutput("t4_wide_req_x7", 32'(bus.req_x), 7);
        runTo(441); checkOutput("t4_wide_req_end", 32'(bus.req), 0);

        // Enable dropped mid-line 3, then restarted
        runTo(466);
        checkOutput("t5_req_before", 32'(bus.req), 1);
        checkOutput("t5_req_x_before", 32'(bus.req_x), 3);
        checkOutput("t5_req_y_before", 32'(bus.req_y), 2);
        en = 1'b0;
        tick();
        checkOutput("t5_req_off", 32'(bus.req), 0);
        checkOutput("t5_req_x_off", 32'(bus.req_x), 0);
        runTo(470);
        checkOutput("t5_de_off", 32'(bus.out_de), 0);
        checkOutput("t5_r_off", 32'(bus.out_vga_r), 0);
        checkOutput("t5_hsync_off", 32'(bus.out_hsync), 1);
        checkOutput("t5_vsync_off", 32'(bus.out_vsync), 1);
        checkOutput("t5_lstart_off", 32'(bus.out_line_start), 0);
        checkOutput("t5_fcount_hold", 32'(bus.out_frame_count), 4);
        runTo(475);
        checkOutput("t5_fstart_idle", 32'(bus.out_frame_start), 0);
        checkOutput("t5_lstart_idle", 32'(bus.out_line_start), 0);
        en = 1'b1;
        runTo(477); checkOutput("t5_fstart_early", 32'(bus.out_frame_start), 0);
        runTo(478); checkOutput("t5_fstart_pulse", 32'(bus.out_frame_start), 1);
        checkOutput("t5_lstart_pulse", 32'(bus.out_line_start), 1);
        runTo(479); checkOutput("t5_fstart_single", 32'(bus.out_frame_start), 0);
        runTo(491); checkOutput("t5_restart_no_req", 32'(bus.req), 0);
        runTo(492); checkOutput("t5_restart_req", 32'(bus.req), 1);
        checkOutput("t5_restart_x", 32'(bus.req_x), 0);
        checkOutput("t5_restart_y", 32'(bus.req_y), 0);

        // Reset mid-frame with a pending update discards it
        runTo(485);
        checkOutput("t6_ready_before", 32'(bus.cfg_ready), 1);
        applyStimulus(2, 4, 2, 3, 1, 4, 1, 2);
        checkOutput("t6_ready_pending", 32'(bus.cfg_ready), 0);
        runTo(498);
        checkOutput("t6_req_before", 32'(bus.req), 1);
        checkOutput("t6_de_before", 32'(bus.out_de), 1);
        checkOutput("t6_r_before", 32'(bus.out_vga_r), 3);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("t6_async");
        repeat (3) @(posedge clk_pixel);
        @(negedge clk_pixel);
        rst_n = 1'b1;
        c = 0;
        #1;
        checkOutput("t6_ready_release", 32'(bus.cfg_ready), 1);
        runTo(17);  checkOutput("t6_def_req", 32'(bus.req), 1);
        checkOutput("t6_def_req_x", 32'(bus.req_x), 0);
        runTo(24);  checkOutput("t6_def_req_x7", 32'(bus.req_x), 7);
        runTo(25);  checkOutput("t6_def_req_end", 32'(bus.req), 0);
        runTo(120); checkOutput("t6_fcount", 32'(bus.out_frame_count), 1);
        checkOutput("t6_ready_still", 32'(bus.cfg_ready), 1);
        runTo(137); checkOutput("t6_def_kept_req", 32'(bus.req), 1);
        runTo(144); checkOutput("t6_def_kept_x7", 32'(bus.req_x), 7);
        runTo(145); checkOutput("t6_def_kept_end", 32'(bus.req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
